shift_arbiter: RTL and testbench
================================

Name: shift_arbiter

Overview:
- Shares one barrel-shift datapath between NUM_REQ requesters using round-robin arbitration.
- Each requester presents an operand and a shift amount over a valid/ready handshake. The block grants one request, sequences it through the shift stage, and returns the result tagged with the requester index.
- One transaction is in flight at a time. The block sits between the request sources and the shifter in the datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_SIZE, 16, operand width in bits (power of 2, >= 4).
- ROTATION, 1'b1, 1 = rotate, 0 = logical shift with zero fill.
- DIRECTION, 1'b1, 1 = shift/rotate left, 0 = right.
- SHIFT_LATENCY, 2, cycles from grant to result ready (>= 1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept, at most one bit high.
- req_data  in  NUM_REQ*DATA_SIZE  flattened operands; requester i occupies bits [i*DATA_SIZE +: DATA_SIZE].
- req_select  in  NUM_REQ*$clog2(DATA_SIZE)  flattened shift amounts, same packing.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  DATA_SIZE  shifted result.
- rsp_id  out  $clog2(NUM_REQ)  index of the requester that owns rsp_data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: asynchronous, on rst high.
  - State = IDLE; rr_ptr = 0.
  - req_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_id = 0, busy = 0.
- State IDLE: req_ready is combinational, a one-hot grant to the first requester with req_valid high, searching from rr_ptr upward with wrap to 0.
  - On handshake (req_valid[i] & req_ready[i]):
    - Capture data and select.
    - Set id = i and rr_ptr = (i+1) mod NUM_REQ.
    - Load lat_cnt = SHIFT_LATENCY-1 and go to SHIFT.
  - No valid requests: stay in IDLE, req_ready = 0.
- State SHIFT: req_ready = 0, lat_cnt decrements each cycle.
  - When lat_cnt == 0: register the shift result into rsp_data, drive rsp_id = id, assert rsp_valid, go to RESP.
  - Grant-to-rsp_valid latency is exactly SHIFT_LATENCY cycles.
- State RESP: rsp_valid stays high; rsp_data and rsp_id are held stable until rsp_ready is high.
  - On rsp_valid & rsp_ready: deassert rsp_valid and return to IDLE. A new grant is possible on the next cycle, so there is no combinational ready->ready path.
- Shift arithmetic, with s = select (0..DATA_SIZE-1):
  - Left rotate: {d, d} shifted left s, upper DATA_SIZE bits taken.
  - Right rotate: mirror of left rotate.
  - Logical shift: vacated bits are 0.
  - s = 0 passes the data through unchanged.
- Requester rules:
  - A requester may drop req_valid before it is granted. Only the cycle of the handshake matters.
  - Several requesters valid in the same cycle: only one is granted. The others wait, and rr_ptr guarantees each is served within NUM_REQ grants.
  - Requests that arrive during SHIFT or RESP are not acknowledged.
- Reset mid-operation: the in-flight transaction is discarded, no response is produced, and rr_ptr returns to 0.

Optional Feature:
- Macro SHIFT_ARB_STATS_EN.
- When defined:
  - Adds output grant_count (16 bits), incremented on every handshake, saturating at 16'hFFFF.
  - Adds output stall_cycles (16 bits), incremented each cycle in RESP with rsp_ready low, also saturating.
  - Both counters clear on rst.
- When undefined: neither port exists, and there is no counter logic.

Test Plan:
- Single request, rotate-left config: requester 0, data 16'h1901, select 3. Response after exactly 2 cycles: rsp_data 16'hC808, rsp_id 0.
- All 4 valid continuously, rsp_ready = 1: grants go in order 0,1,2,3,0. No requester is ever granted twice while another is waiting.
- Backpressure: hold rsp_ready = 0 for 5 cycles in RESP. rsp_data and rsp_id stay stable, req_ready stays 0, and stall_cycles = 5 with the macro enabled.
- Logical shift right (ROTATION = 0, DIRECTION = 0): data 16'h978B, select 4 -> 16'h0978. Select 0 passes the data through unchanged.
- Reset asserted during SHIFT: outputs return to zero immediately without waiting for clk, no rsp_valid follows, and the next grant starts from requester 0.
- Wrap-around: rr_ptr = 3 with requesters 1 and 3 valid -> requester 3 is granted, then requester 1.

Source files
------------

// File: rtl/shift_arbiter_if.sv
// shift_arbiter_if: request/response bus between requesters and the shared shifter.
// master = requester/consumer side, slave = arbiter side.
interface shift_arbiter_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_SIZE = 16
);
  localparam int unsigned SEL_W = $clog2(DATA_SIZE);
  localparam int unsigned ID_W  = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*DATA_SIZE-1:0] req_data;
  logic [NUM_REQ*SEL_W-1:0]     req_select;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [DATA_SIZE-1:0]         rsp_data;
  logic [ID_W-1:0]              rsp_id;

  modport master (
    output req_valid, req_data, req_select, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_data, req_select, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin arbiter sharing one barrel shifter among NUM_REQ
// requesters, one transaction in flight at a time.
// Optional grant/stall statistics counters are enabled by defining SHIFT_ARB_STATS_EN.
module shift_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned DATA_SIZE     = 16,
  parameter logic        ROTATION      = 1'b1,
  parameter logic        DIRECTION     = 1'b1,
  parameter int unsigned SHIFT_LATENCY = 2
) (
  input  logic           clk,
  input  logic           rst,
  shift_arbiter_if.slave bus,
  output logic           busy
`ifdef SHIFT_ARB_STATS_EN
  ,
  output logic [15:0]    grant_count,
  output logic [15:0]    stall_cycles
`endif
);

  localparam int unsigned SEL_W = $clog2(DATA_SIZE);
  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned LAT_W = (SHIFT_LATENCY > 1) ? $clog2(SHIFT_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_e;

  state_e               state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      cand;
  logic                 grant_found;
  logic [ID_W-1:0]      grant_id;
  logic [DATA_SIZE-1:0] grant_data;
  logic [SEL_W-1:0]     grant_sel;
  logic                 hs;
  logic [DATA_SIZE-1:0] data_q;
  logic [SEL_W-1:0]     sel_q;
  logic [ID_W-1:0]      id_q;
  logic [LAT_W-1:0]     lat_q;
  logic [DATA_SIZE-1:0] rsp_data_q;
  logic [ID_W-1:0]      rsp_id_q;
  logic [DATA_SIZE-1:0] shift_res;

  // Round-robin search: first valid requester starting at rr_ptr, wrapping to 0
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  // Handshake happens only in IDLE, on the single granted requester
  assign hs = (state_q == IDLE) && grant_found;

  // Select the granted requester's operand and shift amount
  always_comb begin
    grant_data = '0;
    grant_sel  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        grant_data = bus.req_data[i*DATA_SIZE +: DATA_SIZE];
        grant_sel  = bus.req_select[i*SEL_W +: SEL_W];
      end
    end
  end

  // Rotate is built from two opposing logical shifts; s = 0 leaves the
  // complementary shift at full width, which yields zero.
  always_comb begin
    shift_res = data_q;
    if (ROTATION) begin
      if (DIRECTION)
        shift_res = (data_q << sel_q) | (data_q >> (32'(DATA_SIZE) - 32'(sel_q)));
      else
        shift_res = (data_q >> sel_q) | (data_q << (32'(DATA_SIZE) - 32'(sel_q)));
    end else begin
      if (DIRECTION)
        shift_res = data_q << sel_q;
      else
        shift_res = data_q >> sel_q;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = SHIFT;
      SHIFT:   if (lat_q == '0) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; req_ready is forced low while reset is asserted
  always_comb begin
    bus.req_ready = '0;
    if ((state_q == IDLE) && grant_found && !rst) bus.req_ready[grant_id] = 1'b1;
    bus.rsp_valid = (state_q == RESP);
    bus.rsp_data  = rsp_data_q;
    bus.rsp_id    = rsp_id_q;
    busy          = (state_q != IDLE);
  end

  // Round-robin pointer advances past the requester just granted
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (hs) rr_ptr_d = (32'(grant_id) + 1 == NUM_REQ) ? '0 : grant_id + 1'b1;
  end

  // Operand capture, latency countdown and response register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      data_q     <= '0;
      sel_q      <= '0;
      id_q       <= '0;
      lat_q      <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      if (hs) begin
        data_q <= grant_data;
        sel_q  <= grant_sel;
        id_q   <= grant_id;
        lat_q  <= LAT_W'(SHIFT_LATENCY - 1);
      end else if ((state_q == SHIFT) && (lat_q != '0)) begin
        lat_q <= lat_q - 1'b1;
      end
      if ((state_q == SHIFT) && (lat_q == '0)) begin
        rsp_data_q <= shift_res;
        rsp_id_q   <= id_q;
      end
    end
  end

`ifdef SHIFT_ARB_STATS_EN
  // Saturating handshake and backpressure-stall counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_count  <= '0;
      stall_cycles <= '0;
    end else begin
      if (hs && (grant_count != '1)) grant_count <= grant_count + 16'd1;
      if ((state_q == RESP) && !bus.rsp_ready && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: scoreboard bench for shift_arbiter (rotate-left instance plus
// a logical-shift-right instance).
module tb_shift_arbiter;
  localparam int NR  = 4;
  localparam int W   = 16;
  localparam int SW  = 4;
  localparam int LAT = 2;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic busy, busy_lr;

  always #5 clk = ~clk;

  shift_arbiter_if #(.NUM_REQ(NR), .DATA_SIZE(W)) bus();
  shift_arbiter_if #(.NUM_REQ(NR), .DATA_SIZE(W)) bus_lr();

`ifdef SHIFT_ARB_STATS_EN
  logic [15:0] grant_count, stall_cycles, grant_count_lr, stall_cycles_lr;
`endif

  shift_arbiter #(.NUM_REQ(NR), .DATA_SIZE(W), .ROTATION(1'b1), .DIRECTION(1'b1),
                  .SHIFT_LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy)
`ifdef SHIFT_ARB_STATS_EN
    , .grant_count(grant_count), .stall_cycles(stall_cycles)
`endif
  );

  shift_arbiter #(.NUM_REQ(NR), .DATA_SIZE(W), .ROTATION(1'b0), .DIRECTION(1'b0),
                  .SHIFT_LATENCY(LAT)) u_lr (
    .clk(clk), .rst(rst), .bus(bus_lr), .busy(busy_lr)
`ifdef SHIFT_ARB_STATS_EN
    , .grant_count(grant_count_lr), .stall_cycles(stall_cycles_lr)
`endif
  );

  int   total = 0;
  int   bad   = 0;
  int   m_state;   // 0 idle, 1 shift, 2 resp
  int   m_lat;
  int   m_rr;
  exp_t sbq[$];
  exp_t sbq_lr[$];
  int   glog[$];   // grants observed on the DUT's req_ready

  // Bit-serial reference shifter
  function automatic logic [15:0] shf(input logic [15:0] d, input logic [3:0] s,
                                      input bit rot, input bit left);
    logic [15:0] r;
    r = d;
    for (int i = 0; i < int'(s); i++) begin
      if (left) r = {r[14:0], rot ? r[15] : 1'b0};
      else      r = {rot ? r[0] : 1'b0, r[15:1]};
    end
    return r;
  endfunction

  task automatic set_req(input int i, input logic [15:0] d, input int s);
    bus.req_data[i*W +: W]     = d;
    bus.req_select[i*SW +: SW] = 4'(s);
  endtask

  // One clock cycle: check outputs against the model, advance the model, wait for next negedge
  task automatic tick();
    int         g;
    int         idx;
    logic [3:0] exp_rdy;
    exp_t       e;
    #1;
    total++;
    if (bus.rsp_valid !== (m_state == 2)) begin
      bad++; $display("FAIL rsp_valid got=%b exp=%b", bus.rsp_valid, (m_state == 2));
    end
    total++;
    if (busy !== (m_state != 0)) begin
      bad++; $display("FAIL busy got=%b exp=%b", busy, (m_state != 0));
    end
    if (m_state == 2) begin
      total++;
      if (sbq.size() == 0) begin
        bad++; $display("FAIL sb_empty got=response exp=none");
      end else if (bus.rsp_data !== sbq[0].data || bus.rsp_id !== sbq[0].id) begin
        bad++; $display("FAIL rsp got=%h/%0d exp=%h/%0d", bus.rsp_data, bus.rsp_id,
                        sbq[0].data, sbq[0].id);
      end
    end
    g = -1;
    if (m_state == 0) begin
      for (int k = 0; k < NR; k++) begin
        idx = (m_rr + k) % NR;
        if (g < 0 && bus.req_valid[idx[1:0]]) g = idx;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g[1:0]] = 1'b1;
    total++;
    if (bus.req_ready !== exp_rdy) begin
      bad++; $display("FAIL req_ready got=%b exp=%b", bus.req_ready, exp_rdy);
    end
    for (int k = 0; k < NR; k++)
      if (bus.req_ready[k] === 1'b1 && bus.req_valid[k] === 1'b1) glog.push_back(k);
    case (m_state)
      0: if (g >= 0) begin
        e.id   = g[1:0];
        e.data = shf(bus.req_data[g*W +: W], bus.req_select[g*SW +: SW], 1'b1, 1'b1);
        sbq.push_back(e);
        m_rr    = (g + 1) % NR;
        m_lat   = LAT - 1;
        m_state = 1;
      end
      1: if (m_lat == 0) m_state = 2; else m_lat--;
      default: if (bus.rsp_ready) begin
        if (sbq.size() > 0) void'(sbq.pop_front());
        m_state = 0;
      end
    endcase
    @(negedge clk);
  endtask

  task automatic apply_reset();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    #2 rst = 1'b1;
    m_state = 0; m_rr = 0; m_lat = 0;
    sbq.delete(); glog.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    n = 0;
    while (m_state != 0 && n < 20) begin tick(); n++; end
    total++;
    if (n >= 20 || sbq.size() != 0) begin
      bad++; $display("FAIL drain_timeout got=%0d pending exp=0", sbq.size());
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 4'hF;
    @(negedge clk);
    #1;
    total++;
    if (bus.req_ready !== 4'b0 || bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b/%b/%b exp=0000/0/0", bus.req_ready, bus.rsp_valid, busy);
    end
    total++;
    if (bus.rsp_data !== 16'h0 || bus.rsp_id !== 2'd0) begin
      bad++; $display("FAIL reset_rsp got=%h/%0d exp=0000/0", bus.rsp_data, bus.rsp_id);
    end
`ifdef SHIFT_ARB_STATS_EN
    total++;
    if (grant_count !== 16'd0 || stall_cycles !== 16'd0) begin
      bad++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", grant_count, stall_cycles);
    end
`endif
    @(negedge clk);
    bus.req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    int n;
    set_req(0, 16'h1901, 3);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = '0;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 10) begin tick(); n++; end
    total++;
    if (n != LAT) begin
      bad++; $display("FAIL single_latency got=%0d exp=%0d", n, LAT);
    end
    total++;
    if (bus.rsp_data !== 16'hC808 || bus.rsp_id !== 2'd0) begin
      bad++; $display("FAIL single_rsp got=%h/%0d exp=c808/0", bus.rsp_data, bus.rsp_id);
    end
    drain();
  endtask

  task automatic test_round_robin();
    int n;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    apply_reset();
    for (int i = 0; i < NR; i++) set_req(i, (16'h1111 * 16'(i + 1)) ^ 16'h0A50, i * 3 + 1);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'hF;
    n = 0;
    while (glog.size() < 5 && n < 60) begin tick(); n++; end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (i >= glog.size() || glog[i] != exp_order[i]) begin
        bad++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", i,
                        (i < glog.size()) ? glog[i] : -1, exp_order[i]);
      end
    end
`ifdef SHIFT_ARB_STATS_EN
    total++;
    if (grant_count !== 16'd5) begin
      bad++; $display("FAIL grant_count got=%0d exp=5", grant_count);
    end
`endif
    drain();
  endtask

  task automatic test_backpressure();
    int n;
`ifdef SHIFT_ARB_STATS_EN
    logic [15:0] s0;
`endif
    set_req(2, 16'hBEEF, 7);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = 4'b1011;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 10) begin tick(); n++; end
    total++;
    if (n >= 10) begin
      bad++; $display("FAIL bp_timeout got=no_rsp exp=rsp");
    end
`ifdef SHIFT_ARB_STATS_EN
    s0 = stall_cycles;
`endif
    repeat (5) tick();
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2) begin
      bad++; $display("FAIL bp_hold got=%b/%0d exp=1/2", bus.rsp_valid, bus.rsp_id);
    end
`ifdef SHIFT_ARB_STATS_EN
    total++;
    if (stall_cycles - s0 !== 16'd5) begin
      bad++; $display("FAIL stall_cycles got=%0d exp=5", stall_cycles - s0);
    end
`endif
    drain();
  endtask

  task automatic test_wrap();
    int n;
    apply_reset();
    set_req(2, 16'h1234, 2);
    bus.req_valid = 4'b0100;
    tick();
    drain();
    set_req(1, 16'h8001, 1);
    set_req(3, 16'h0F0F, 15);
    glog.delete();
    bus.req_valid = 4'b1010;
    n = 0;
    while (glog.size() < 2 && n < 40) begin tick(); n++; end
    total++;
    if (glog.size() < 2 || glog[0] != 3 || glog[1] != 1) begin
      bad++; $display("FAIL wrap_order got=%0d,%0d exp=3,1",
                      (glog.size() > 0) ? glog[0] : -1, (glog.size() > 1) ? glog[1] : -1);
    end
    drain();
  endtask

  task automatic lr_one(input int r, input logic [15:0] d, input int s, input logic [15:0] lit);
    int   n;
    exp_t e;
    logic [3:0] rdy;
    bus_lr.req_data[r*W +: W]     = d;
    bus_lr.req_select[r*SW +: SW] = 4'(s);
    e.id   = 2'(r);
    e.data = shf(d, 4'(s), 1'b0, 1'b0);
    sbq_lr.push_back(e);
    bus_lr.rsp_ready = 1'b1;
    bus_lr.req_valid = '0;
    bus_lr.req_valid[r] = 1'b1;
    rdy = bus_lr.req_valid;
    #1;
    total++;
    if (bus_lr.req_ready !== rdy) begin
      bad++; $display("FAIL lr_ready got=%b exp=%b", bus_lr.req_ready, rdy);
    end
    tick();
    bus_lr.req_valid = '0;
    n = 0;
    while (bus_lr.rsp_valid !== 1'b1 && n < 10) begin tick(); n++; end
    total++;
    if (n != LAT) begin
      bad++; $display("FAIL lr_latency got=%0d exp=%0d", n, LAT);
    end
    if (sbq_lr.size() > 0) begin
      e = sbq_lr.pop_front();
      total++;
      if (bus_lr.rsp_data !== e.data || bus_lr.rsp_id !== e.id) begin
        bad++; $display("FAIL lr_rsp got=%h/%0d exp=%h/%0d", bus_lr.rsp_data, bus_lr.rsp_id, e.data, e.id);
      end
    end
    total++;
    if (bus_lr.rsp_data !== lit) begin
      bad++; $display("FAIL lr_literal got=%h exp=%h", bus_lr.rsp_data, lit);
    end
    tick();
    total++;
    if (bus_lr.rsp_valid !== 1'b0) begin
      bad++; $display("FAIL lr_release got=%b exp=0", bus_lr.rsp_valid);
    end
  endtask

  task automatic test_logical_right();
    lr_one(1, 16'h978B, 4, 16'h0978);
    lr_one(3, 16'hA5C3, 0, 16'hA5C3);
  endtask

  task automatic test_mid_reset();
    set_req(2, 16'h00F0, 1);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = 4'hF;
    tick();
    #2 rst = 1'b1;
    #1;
    total++;
    if (bus.req_ready !== 4'b0 || bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL midrst_ctrl got=%b/%b/%b exp=0000/0/0", bus.req_ready, bus.rsp_valid, busy);
    end
    total++;
    if (bus.rsp_data !== 16'h0 || bus.rsp_id !== 2'd0) begin
      bad++; $display("FAIL midrst_rsp got=%h/%0d exp=0000/0", bus.rsp_data, bus.rsp_id);
    end
    m_state = 0; m_rr = 0; m_lat = 0;
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = '0;
    repeat (4) tick();
    glog.delete();
    bus.req_valid = 4'hF;
    tick();
    total++;
    if (glog.size() == 0 || glog[0] != 0) begin
      bad++; $display("FAIL midrst_grant got=%0d exp=0", (glog.size() > 0) ? glog[0] : -1);
    end
    drain();
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = '0; bus.req_data = '0; bus.req_select = '0; bus.rsp_ready = 1'b1;
    bus_lr.req_valid = '0; bus_lr.req_data = '0; bus_lr.req_select = '0; bus_lr.rsp_ready = 1'b1;
    m_state = 0; m_rr = 0; m_lat = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_logical_right();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
